// File: rtl/video_pkg.sv
// Shared video timing package: 1024x768 @ 60 Hz defaults and derived totals,
// imported by every screen-side module.
package video_pkg;
  localparam int H_ACTIVE_DEF = 1024;
  localparam int H_FP_DEF     = 24;
  localparam int H_SYNC_DEF   = 136;
  localparam int H_BP_DEF     = 160;
  localparam int V_ACTIVE_DEF = 768;
  localparam int V_FP_DEF     = 3;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 29;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF; // 1344
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF; // 806

  localparam int HW = 11; // column counter width
  localparam int VW = 10; // line counter width
  localparam int FW = 6;  // frame counter width

  // One pixel's worth of timing state; every field is registered together
  // so all outputs describe the same (hcount, vcount) point.
  typedef struct packed {
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          hsync_n;
    logic          vsync_n;
    logic          active;
    logic          new_frame;
    logic [FW-1:0] frame_count;
  } vid_timing_t;
endpackage

// File: rtl/video_sig_gen_if.sv
// Timing bundle as seen by consumers of the signal generator.
interface video_sig_gen_if;
  import video_pkg::*;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          active_draw;
  logic          new_frame;
  logic [FW-1:0] frame_count;

  modport master (output hcount, vcount, hsync, vsync, active_draw, new_frame, frame_count);
  modport slave  (input  hcount, vcount, hsync, vsync, active_draw, new_frame, frame_count);
endinterface

// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel/line counters plus syncs, active-area flag,
// start-of-vblank pulse and frame counter, all registered with zero skew.
module video_sig_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          active_draw_out,
  output logic          new_frame_out,
  output logic [FW-1:0] frame_count_out
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All compare points pre-sized to counter width.
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Reset parks the counters on the last pixel so the first edge lands on (0,0).
  localparam vid_timing_t RST_VAL = '{
    hcount: H_LAST, vcount: V_LAST, hsync_n: 1'b1, vsync_n: 1'b1,
    active: 1'b0, new_frame: 1'b0, frame_count: '0
  };

  vid_timing_t tim_q, tim_d;
  logic        h_wrap;

  // Next-state: advance counters, then decode every flag from the *next* counts
  // so the flags and counts are registered on the same edge.
  always_comb begin
    tim_d  = tim_q;
    h_wrap = (tim_q.hcount == H_LAST);
    tim_d.hcount = h_wrap ? '0 : tim_q.hcount + HW'(1);
    if (h_wrap) tim_d.vcount = (tim_q.vcount == V_LAST) ? '0 : tim_q.vcount + VW'(1);
    tim_d.hsync_n   = !((tim_d.hcount >= HS_BEG) && (tim_d.hcount < HS_END));
    tim_d.vsync_n   = !((tim_d.vcount >= VS_BEG) && (tim_d.vcount < VS_END));
    tim_d.active    = (tim_d.hcount < H_ACT) && (tim_d.vcount < V_ACT);
    tim_d.new_frame = (tim_d.hcount == H_ACT) && (tim_d.vcount == V_ACT);
    tim_d.frame_count = tim_q.frame_count + {{(FW-1){1'b0}}, tim_d.new_frame};
  end

  // Timing state register; async reset abandons the frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tim_q <= RST_VAL;
    else        tim_q <= tim_d;
  end

  assign hcount_out      = tim_q.hcount;
  assign vcount_out      = tim_q.vcount;
  assign hsync_out       = tim_q.hsync_n;
  assign vsync_out       = tim_q.vsync_n;
  assign active_draw_out = tim_q.active;
  assign new_frame_out   = tim_q.new_frame;
  assign frame_count_out = tim_q.frame_count;
endmodule
